// File: rtl/approx_mult_error_monitor.sv
// Error-statistics monitor for the 16x16 approximate multiplier: exact product vs. approximate,
// accumulated over a programmed window (2-stage pipeline, counts/ED sum/max ED with operands).
module approx_mult_error_monitor #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 32,
  parameter int SUM_W = 48
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 start,
  input  logic [CNT_W-1:0]     num_samples,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_x,
  input  logic [2*WIDTH-1:0]   in_approx,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     sample_count,
  output logic [CNT_W-1:0]     error_count,
  output logic [SUM_W-1:0]     ed_sum,
  output logic [2*WIDTH-1:0]   ed_max,
  output logic [WIDTH-1:0]     max_a,
  output logic [WIDTH-1:0]     max_x,
  output logic                 sum_sat
);

  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   target_q, target_d;
  logic [CNT_W-1:0]   accepted_q, accepted_d;
  logic               s1_vld_q, s1_vld_d;
  logic [WIDTH-1:0]   s1_a_q, s1_a_d, s1_x_q, s1_x_d;
  logic [PW-1:0]      s1_approx_q, s1_approx_d, s1_exact_q, s1_exact_d;
  logic               s2_vld_q, s2_vld_d;
  logic [WIDTH-1:0]   s2_a_q, s2_a_d, s2_x_q, s2_x_d;
  logic [PW-1:0]      s2_ed_q, s2_ed_d;
  logic               s2_err_q, s2_err_d;
  logic [CNT_W-1:0]   sample_count_q, sample_count_d;
  logic [CNT_W-1:0]   error_count_q, error_count_d;
  logic [SUM_W-1:0]   ed_sum_q, ed_sum_d;
  logic [PW-1:0]      ed_max_q, ed_max_d;
  logic [WIDTH-1:0]   max_a_q, max_a_d, max_x_q, max_x_d;
  logic               sum_sat_q, sum_sat_d;

  logic               hs;
  logic [SUM_W:0]     sum_wide;

  assign in_ready = (state_q == RUN) && (accepted_q < target_q);
  assign hs       = in_valid && in_ready;
  assign busy     = (state_q == RUN) || (state_q == DRAIN);
  assign done     = (state_q == DONE);
  // One extra bit catches the carry that signals saturation.
  assign sum_wide = {1'b0, ed_sum_q} + (SUM_W+1)'(s2_ed_q);

  always_comb begin
    state_d        = state_q;
    target_d       = target_q;
    accepted_d     = accepted_q;
    s1_vld_d       = hs;
    s1_a_d         = s1_a_q;
    s1_x_d         = s1_x_q;
    s1_approx_d    = s1_approx_q;
    s1_exact_d     = s1_exact_q;
    s2_vld_d       = s1_vld_q;
    s2_a_d         = s2_a_q;
    s2_x_d         = s2_x_q;
    s2_ed_d        = s2_ed_q;
    s2_err_d       = s2_err_q;
    sample_count_d = sample_count_q;
    error_count_d  = error_count_q;
    ed_sum_d       = ed_sum_q;
    ed_max_d       = ed_max_q;
    max_a_d        = max_a_q;
    max_x_d        = max_x_q;
    sum_sat_d      = sum_sat_q;

    if (hs) begin
      s1_a_d      = in_a;
      s1_x_d      = in_x;
      s1_approx_d = in_approx;
      s1_exact_d  = PW'(in_a) * PW'(in_x);
      accepted_d  = accepted_q + CNT_W'(1);
    end

    if (s1_vld_q) begin
      s2_a_d   = s1_a_q;
      s2_x_d   = s1_x_q;
      s2_ed_d  = (s1_approx_q >= s1_exact_q) ? (s1_approx_q - s1_exact_q)
                                             : (s1_exact_q - s1_approx_q);
      s2_err_d = (s1_approx_q != s1_exact_q);
    end

    if (s2_vld_q) begin
      sample_count_d = sample_count_q + CNT_W'(1);
      error_count_d  = error_count_q + CNT_W'(s2_err_q);
      if (sum_wide[SUM_W]) begin
        ed_sum_d  = '1;
        sum_sat_d = 1'b1;
      end else begin
        ed_sum_d = sum_wide[SUM_W-1:0];
      end
      // Strict compare: ties keep the operands of the earlier sample.
      if (s2_ed_q > ed_max_q) begin
        ed_max_d = s2_ed_q;
        max_a_d  = s2_a_q;
        max_x_d  = s2_x_q;
      end
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          target_d       = num_samples;
          accepted_d     = '0;
          sample_count_d = '0;
          error_count_d  = '0;
          ed_sum_d       = '0;
          ed_max_d       = '0;
          max_a_d        = '0;
          max_x_d        = '0;
          sum_sat_d      = 1'b0;
          state_d        = (num_samples == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (hs && (accepted_d == target_q)) state_d = DRAIN;
      end
      DRAIN: begin
        if (!s1_vld_q && !s2_vld_q) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    if (clear) begin
      state_d        = IDLE;
      target_d       = '0;
      accepted_d     = '0;
      s1_vld_d       = 1'b0;
      s1_a_d         = '0;
      s1_x_d         = '0;
      s1_approx_d    = '0;
      s1_exact_d     = '0;
      s2_vld_d       = 1'b0;
      s2_a_d         = '0;
      s2_x_d         = '0;
      s2_ed_d        = '0;
      s2_err_d       = 1'b0;
      sample_count_d = '0;
      error_count_d  = '0;
      ed_sum_d       = '0;
      ed_max_d       = '0;
      max_a_d        = '0;
      max_x_d        = '0;
      sum_sat_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      target_q       <= '0;
      accepted_q     <= '0;
      s1_vld_q       <= 1'b0;
      s1_a_q         <= '0;
      s1_x_q         <= '0;
      s1_approx_q    <= '0;
      s1_exact_q     <= '0;
      s2_vld_q       <= 1'b0;
      s2_a_q         <= '0;
      s2_x_q         <= '0;
      s2_ed_q        <= '0;
      s2_err_q       <= 1'b0;
      sample_count_q <= '0;
      error_count_q  <= '0;
      ed_sum_q       <= '0;
      ed_max_q       <= '0;
      max_a_q        <= '0;
      max_x_q        <= '0;
      sum_sat_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      target_q       <= target_d;
      accepted_q     <= accepted_d;
      s1_vld_q       <= s1_vld_d;
      s1_a_q         <= s1_a_d;
      s1_x_q         <= s1_x_d;
      s1_approx_q    <= s1_approx_d;
      s1_exact_q     <= s1_exact_d;
      s2_vld_q       <= s2_vld_d;
      s2_a_q         <= s2_a_d;
      s2_x_q         <= s2_x_d;
      s2_ed_q        <= s2_ed_d;
      s2_err_q       <= s2_err_d;
      sample_count_q <= sample_count_d;
      error_count_q  <= error_count_d;
      ed_sum_q       <= ed_sum_d;
      ed_max_q       <= ed_max_d;
      max_a_q        <= max_a_d;
      max_x_q        <= max_x_d;
      sum_sat_q      <= sum_sat_d;
    end
  end

  assign sample_count = sample_count_q;
  assign error_count  = error_count_q;
  assign ed_sum       = ed_sum_q;
  assign ed_max       = ed_max_q;
  assign max_a        = max_a_q;
  assign max_x        = max_x_q;
  assign sum_sat      = sum_sat_q;

endmodule

// File: tb/tb_approx_mult_error_monitor.sv
// Directed bench for approx_mult_error_monitor; a second instance with SUM_W=33 exercises saturation.
module tb_approx_mult_error_monitor;

  logic        clk = 1'b0;
  logic        rst, clear, start, in_valid;
  logic [31:0] num_samples, in_approx;
  logic [15:0] in_a, in_x;

  logic        in_ready, busy, done, sum_sat;
  logic [31:0] sample_count, error_count, ed_max;
  logic [47:0] ed_sum;
  logic [15:0] max_a, max_x;

  logic        s_in_ready, s_busy, s_done, s_sum_sat;
  logic [31:0] s_sample_count, s_error_count, s_ed_max;
  logic [32:0] s_ed_sum;
  logic [15:0] s_max_a, s_max_x;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  approx_mult_error_monitor #(.WIDTH(16), .CNT_W(32), .SUM_W(48)) dut (
    .clk(clk), .rst(rst), .clear(clear), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_x(in_x), .in_approx(in_approx),
    .busy(busy), .done(done), .sample_count(sample_count), .error_count(error_count),
    .ed_sum(ed_sum), .ed_max(ed_max), .max_a(max_a), .max_x(max_x), .sum_sat(sum_sat));

  approx_mult_error_monitor #(.WIDTH(16), .CNT_W(32), .SUM_W(33)) dut_sat (
    .clk(clk), .rst(rst), .clear(clear), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_a(in_a), .in_x(in_x), .in_approx(in_approx),
    .busy(s_busy), .done(s_done), .sample_count(s_sample_count), .error_count(s_error_count),
    .ed_sum(s_ed_sum), .ed_max(s_ed_max), .max_a(s_max_a), .max_x(s_max_x), .sum_sat(s_sum_sat));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] x,
                       input logic [31:0] ap);
    in_valid  = v;
    in_a      = a;
    in_x      = x;
    in_approx = ap;
    tick();
  endtask

  task automatic do_start(input logic [31:0] n);
    in_valid    = 1'b0;
    start       = 1'b1;
    num_samples = n;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; start = 1'b0; num_samples = '0;
    in_valid = 1'b0; in_a = '0; in_x = '0; in_approx = '0;
    #2;
    n_vec++; if ({in_ready, busy, done, sum_sat} !== 4'b0) begin n_err++; $display("FAIL reset_flags got %b exp 0000", {in_ready, busy, done, sum_sat}); end
    n_vec++; if (sample_count !== 32'd0 || error_count !== 32'd0 || ed_sum !== 48'd0) begin n_err++; $display("FAIL reset_counters got %0d/%0d/%0d exp 0/0/0", sample_count, error_count, ed_sum); end
    tick();
    rst = 1'b0;
    tick();
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL idle_in_ready got %b exp 0", in_ready); end
  endtask

  task automatic test_basic_window();
    do_start(32'd4);
    n_vec++; if (in_ready !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL t1_run got rdy=%b busy=%b exp 1 1", in_ready, busy); end
    drive(1'b1, 16'd3, 16'd5, 32'd15);
    drive(1'b1, 16'd100, 16'd200, 32'd19990);
    drive(1'b1, 16'd255, 16'd255, 32'd65000);
    drive(1'b1, 16'd0, 16'd7, 32'd0);
    in_valid = 1'b0;
    n_vec++; if (in_ready !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL t1_drain got rdy=%b busy=%b exp 0 1", in_ready, busy); end
    tick(); tick();
    n_vec++; if (sample_count !== 32'd4 || done !== 1'b0) begin n_err++; $display("FAIL t1_k2 got cnt=%0d done=%b exp 4 0", sample_count, done); end
    tick();
    n_vec++; if (done !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL t1_done got done=%b busy=%b exp 1 0", done, busy); end
    n_vec++; if (error_count !== 32'd2) begin n_err++; $display("FAIL t1_error_count got %0d exp 2", error_count); end
    n_vec++; if (ed_sum !== 48'd35) begin n_err++; $display("FAIL t1_ed_sum got %0d exp 35", ed_sum); end
    n_vec++; if (ed_max !== 32'd25 || max_a !== 16'd255 || max_x !== 16'd255) begin n_err++; $display("FAIL t1_max got %0d a=%0d x=%0d exp 25 255 255", ed_max, max_a, max_x); end
  endtask

  task automatic test_zero_window();
    do_start(32'd0);
    n_vec++; if (done !== 1'b1 || in_ready !== 1'b0) begin n_err++; $display("FAIL t2_done got done=%b rdy=%b exp 1 0", done, in_ready); end
    n_vec++; if (sample_count !== 32'd0 || error_count !== 32'd0 || ed_sum !== 48'd0 || ed_max !== 32'd0) begin n_err++; $display("FAIL t2_stats got %0d/%0d/%0d/%0d exp all 0", sample_count, error_count, ed_sum, ed_max); end
    drive(1'b1, 16'd9, 16'd9, 32'd1);
    n_vec++; if (in_ready !== 1'b0 || sample_count !== 32'd0) begin n_err++; $display("FAIL t2_ignore got rdy=%b cnt=%0d exp 0 0", in_ready, sample_count); end
    in_valid = 1'b0;
  endtask

  task automatic test_gapped_valid();
    do_start(32'd3);
    drive(1'b1, 16'd2, 16'd3, 32'd6);
    drive(1'b0, 16'd9, 16'd9, 32'd0);
    drive(1'b1, 16'd4, 16'd4, 32'd17);
    drive(1'b0, 16'd9, 16'd9, 32'd0);
    drive(1'b1, 16'd1, 16'd1, 32'd0);
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL t3_drain_rdy%0d got %b exp 0", i, in_ready); end
      drive(1'b1, 16'd7, 16'd7, 32'd0);
    end
    n_vec++; if (done !== 1'b1 || in_ready !== 1'b0) begin n_err++; $display("FAIL t3_done got done=%b rdy=%b exp 1 0", done, in_ready); end
    drive(1'b1, 16'd7, 16'd7, 32'd0);
    in_valid = 1'b0;
    n_vec++; if (sample_count !== 32'd3 || error_count !== 32'd2 || ed_sum !== 48'd2) begin n_err++; $display("FAIL t3_stats got %0d/%0d/%0d exp 3/2/2", sample_count, error_count, ed_sum); end
    n_vec++; if (ed_max !== 32'd1 || max_a !== 16'd4 || max_x !== 16'd4) begin n_err++; $display("FAIL t3_max got %0d a=%0d x=%0d exp 1 4 4", ed_max, max_a, max_x); end
  endtask

  task automatic test_tie();
    do_start(32'd2);
    drive(1'b1, 16'd10, 16'd10, 32'd75);
    drive(1'b1, 16'd5, 16'd5, 32'd0);
    in_valid = 1'b0;
    tick(); tick(); tick();
    n_vec++; if (ed_max !== 32'd25 || max_a !== 16'd10 || max_x !== 16'd10) begin n_err++; $display("FAIL t4_tie got %0d a=%0d x=%0d exp 25 10 10", ed_max, max_a, max_x); end
    n_vec++; if (ed_sum !== 48'd50 || done !== 1'b1) begin n_err++; $display("FAIL t4_sum got %0d done=%b exp 50 1", ed_sum, done); end
  endtask

  task automatic test_saturation();
    do_start(32'd3);
    for (int i = 0; i < 3; i++) drive(1'b1, 16'hFFFF, 16'hFFFF, 32'd0);
    in_valid = 1'b0;
    tick(); tick(); tick();
    n_vec++; if (s_ed_sum !== 33'd8589934591 || s_sum_sat !== 1'b1) begin n_err++; $display("FAIL t5_sat got %0d sat=%b exp 8589934591 1", s_ed_sum, s_sum_sat); end
    n_vec++; if (s_error_count !== 32'd3 || s_done !== 1'b1) begin n_err++; $display("FAIL t5_err got %0d done=%b exp 3 1", s_error_count, s_done); end
    n_vec++; if (ed_sum !== 48'd12884508675 || sum_sat !== 1'b0) begin n_err++; $display("FAIL t5_wide got %0d sat=%b exp 12884508675 0", ed_sum, sum_sat); end
    n_vec++; if (ed_max !== 32'd4294836225 || max_a !== 16'hFFFF) begin n_err++; $display("FAIL t5_max got %0d a=%0d exp 4294836225 65535", ed_max, max_a); end
  endtask

  task automatic test_reset_mid_run();
    do_start(32'd5);
    drive(1'b1, 16'd1, 16'd1, 32'd3);
    drive(1'b1, 16'd1, 16'd1, 32'd3);
    rst = 1'b1;
    #2;
    n_vec++; if ({in_ready, busy, done, sum_sat} !== 4'b0) begin n_err++; $display("FAIL t6_flags got %b exp 0000", {in_ready, busy, done, sum_sat}); end
    n_vec++; if (sample_count !== 32'd0 || ed_sum !== 48'd0 || ed_max !== 32'd0 || max_a !== 16'd0 || max_x !== 16'd0) begin n_err++; $display("FAIL t6_stats got %0d/%0d/%0d/%0d/%0d exp all 0", sample_count, ed_sum, ed_max, max_a, max_x); end
    in_valid = 1'b0;
    tick(); tick();
    n_vec++; if (sample_count !== 32'd0 || busy !== 1'b0) begin n_err++; $display("FAIL t6_hold got cnt=%0d busy=%b exp 0 0", sample_count, busy); end
    rst = 1'b0;
    tick();
    do_start(32'd1);
    drive(1'b1, 16'd2, 16'd2, 32'd4);
    in_valid = 1'b0;
    tick(); tick(); tick();
    n_vec++; if (sample_count !== 32'd1 || error_count !== 32'd0 || ed_sum !== 48'd0 || done !== 1'b1) begin n_err++; $display("FAIL t6_after got %0d/%0d/%0d done=%b exp 1/0/0 1", sample_count, error_count, ed_sum, done); end
  endtask

  initial begin
    test_reset();
    test_basic_window();
    test_zero_window();
    test_gapped_valid();
    test_tie();
    test_saturation();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
